// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the buffered UART transmitter and the UART
// receiver that runs on the same clock.
//   uart_state_e             frame FSM state encoding
//   PARITY_NONE/EVEN/ODD     values for the PARITY_MODE parameter
//   CLKS_PER_BIT_10M_115200  bit period in clocks for 115200 baud at 10 MHz
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        CLEAN_UP   = 3'd5
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int UART_CLK_HZ = 10_000_000;
    localparam int UART_BAUD   = 115_200;
    // Rounded to the nearest integer divisor (evaluates to 87).
    localparam int CLKS_PER_BIT_10M_115200 = (UART_CLK_HZ + UART_BAUD / 2) / UART_BAUD;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with first-word fall-through read port.
//   clk, rst   clock and synchronous active-high reset (pointers only)
//   wr_en      write strobe; ignored (and flagged) when full
//   wr_data    word to store
//   rd_en      pop strobe; ignored when empty
//   rd_data    word at the head of the queue, valid while !empty
//   full       DEPTH words stored
//   empty      no words stored
//   count      words stored, 0..DEPTH
//   overflow   one-cycle pulse after a write was dropped
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             do_wr, do_rd;

    // Pointers carry one extra MSB so full and empty are distinguishable and
    // the subtraction for count stays correct across wrap-around.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = overflow_q;

    // full is taken from the registered pointers, so a pop in the same cycle
    // never makes room for a write to a full FIFO.
    always_comb begin
        do_wr      = wr_en && !full;
        do_rd      = rd_en && !empty;
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, do_rd};
        overflow_d = wr_en && full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter, frames sent back-to-back.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit,
// STOP_BITS stop bits, then one CLEAN_UP cycle and one IDLE cycle.
// Build option: define UART_PARITY_EN to compile in the parity bit; without
// it PARITY_MODE is ignored and no parity state or logic exists.
//   clk       system clock, rising edge
//   rst       synchronous active-high reset; aborts the frame, empties FIFO
//   wr_en     write strobe, one word per cycle
//   wr_data   word to send
//   full      FIFO full, further writes are dropped
//   count     words queued, not counting the frame in flight
//   overflow  one-cycle pulse after a dropped write
//   tx        registered serial output, idle high
//   busy      FSM not in IDLE
//   done      one-cycle pulse in CLEAN_UP, right after the last stop cycle
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_10M_115200,
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          tx,
    output logic                          busy,
    output logic                          done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_WIDTH);
    localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

`ifdef UART_PARITY_EN
    localparam uart_state_e AFTER_DATA =
        (PARITY_MODE != PARITY_NONE) ? PARITY_BIT : STOP_BIT;
`else
    localparam uart_state_e AFTER_DATA = STOP_BIT;
    // PARITY_MODE only has an effect when parity support is compiled in.
    logic unused_parity_mode;
    assign unused_parity_mode = (PARITY_MODE != PARITY_NONE);
`endif

    uart_state_e             state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [STOP_W-1:0]       stop_q, stop_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    tx_q, tx_d;
`ifdef UART_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    logic                    fifo_pop;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_rd_data;
    logic                    baud_last;

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (fifo_pop),
        .rd_data  (fifo_rd_data),
        .full     (full),
        .empty    (fifo_empty),
        .count    (count),
        .overflow (overflow)
    );

    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    // State and control counters are reset; the shift register and parity
    // flop are loaded on every pop and need no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            stop_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            stop_q    <= stop_d;
            tx_q      <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q  <= shreg_d;
`ifdef UART_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        stop_d    = stop_q;
        shreg_d   = shreg_q;
        fifo_pop  = 1'b0;
`ifdef UART_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shreg_d   = fifo_rd_data;
                    bit_idx_d = '0;
                    state_d   = START_BIT;
`ifdef UART_PARITY_EN
                    // Parity is taken from the whole word before shifting.
                    parity_d  = (^fifo_rd_data) ^ (PARITY_MODE == PARITY_ODD);
`endif
                end
            end
            START_BIT: begin
                if (baud_last) begin
                    state_d = DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (baud_last) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        stop_d  = '0;
                        state_d = AFTER_DATA;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY_BIT: begin
                if (baud_last) begin
                    stop_d  = '0;
                    state_d = STOP_BIT;
                end
            end
`endif
            STOP_BIT: begin
                if (baud_last) begin
                    if (stop_q == STOP_W'(STOP_BITS - 1)) begin
                        state_d = CLEAN_UP;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            CLEAN_UP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The baud counter restarts on every state change and on every bit
        // boundary inside a state, and rests at zero in IDLE/CLEAN_UP.
        if ((state_d != state_q) || baud_last ||
            (state_q == IDLE) || (state_q == CLEAN_UP)) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + 1'b1;
        end
    end

    // Output logic: tx is registered, so its next value follows the next
    // state; this makes tx fall on the same edge that enters START_BIT.
    always_comb begin
        case (state_d)
            START_BIT:  tx_d = 1'b0;
            DATA_BITS:  tx_d = shreg_d[0];
`ifdef UART_PARITY_EN
            PARITY_BIT: tx_d = parity_d;
`endif
            default:    tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == CLEAN_UP);

endmodule
